// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 style divider: restoring radix-2 mantissa division,
// round-to-nearest-even, flush-to-zero, with special-operand short path.
module fp_div_seq #(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   N1,
  input  logic [EXP_W+MAN_W:0]   N2,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero,
  output logic                   invalid
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned BIAS   = (2 ** (EXP_W - 1)) - 1;
  localparam int unsigned XW     = EXP_W + 2;
  localparam int unsigned QW     = MAN_W + 3;
  localparam int unsigned CNT_W  = $clog2(QW);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t state, state_nx;

  logic [MAN_W+1:0] rem;
  logic [MAN_W:0]   dvs;
  logic [QW-1:0]    quo;
  logic [CNT_W-1:0] cnt;
  logic [XW-1:0]    exp_q;
  logic             sign;

  // Operand decode (only meaningful on the accepting edge)
  logic             s1, s2;
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] f1, f2;
  logic             z1, z2, m1, m2, nan1, nan2, inf1, inf2;
  logic             special, sp_inv, sp_dbz, sp_inf;
  logic [W-1:0]     sp_out;
  logic [XW-1:0]    exp_init;

  always_comb begin
    s1       = N1[W-1];
    s2       = N2[W-1];
    e1       = N1[W-2 -: EXP_W];
    e2       = N2[W-2 -: EXP_W];
    f1       = N1[MAN_W-1:0];
    f2       = N2[MAN_W-1:0];
    z1       = (e1 == '0);
    z2       = (e2 == '0);
    m1       = &e1;
    m2       = &e2;
    nan1     = m1 & (|f1);
    nan2     = m2 & (|f2);
    inf1     = m1 & ~(|f1);
    inf2     = m2 & ~(|f2);
    special  = z1 | z2 | m1 | m2;
    sp_inv   = nan1 | nan2 | (z1 & z2) | (inf1 & inf2);
    sp_dbz   = ~sp_inv & z2 & ~z1 & ~m1;
    sp_inf   = ~sp_inv & (sp_dbz | (inf1 & ~m2) | (inf1 & z2));
    exp_init = XW'(e1) - XW'(e2) + XW'(BIAS);
    if (sp_inv)
      sp_out = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (sp_inf)
      sp_out = {s1 ^ s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      sp_out = {s1 ^ s2, {(W-1){1'b0}}};
  end

  // One restoring-division step
  logic             q_bit;
  logic [MAN_W+1:0] rem_sub;
  logic [MAN_W+1:0] rem_nx;

  always_comb begin
    q_bit   = (rem >= {1'b0, dvs});
    rem_sub = q_bit ? (rem - {1'b0, dvs}) : rem;
    rem_nx  = rem_sub << 1;
  end

  // Normalise, round to nearest even, range-check the exponent
  logic             norm, guard, sticky, carry;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic [XW-1:0]    exp_f;
  logic [W-1:0]     rnd_out;

  always_comb begin
    norm   = quo[QW-1];
    mant   = norm ? quo[QW-1:2] : quo[QW-2:1];
    guard  = norm ? quo[1] : quo[0];
    sticky = (norm & quo[0]) | (|rem);
    mant_r = {1'b0, mant} + (MAN_W+2)'(guard & (sticky | mant[0]));
    carry  = mant_r[MAN_W+1];
    frac   = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    exp_f  = exp_q - XW'(!norm) + XW'(carry);
    if (!exp_f[XW-1] && (exp_f >= XW'((2 ** EXP_W) - 1)))
      rnd_out = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (exp_f[XW-1] || (exp_f == '0))
      rnd_out = {sign, {(W-1){1'b0}}};
    else
      rnd_out = {sign, exp_f[EXP_W-1:0], frac};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = special ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(QW - 1)) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      dvs         <= '0;
      quo         <= '0;
      cnt         <= '0;
      exp_q       <= '0;
      sign        <= 1'b0;
      out         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state_nx == DONE);
      case (state)
        IDLE: if (start) begin
          sign        <= s1 ^ s2;
          rem         <= {2'b01, f1};
          dvs         <= {1'b1, f2};
          quo         <= '0;
          cnt         <= '0;
          exp_q       <= exp_init;
          div_by_zero <= special & sp_dbz;
          invalid     <= special & sp_inv;
          if (special) out <= sp_out;
        end
        CALC: begin
          rem <= rem_nx;
          quo <= {quo[QW-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
        end
        ROUND:   out <= rnd_out;
        default: ;
      endcase
    end
  end

endmodule
